// File: rtl/spu_host_ctrl.sv
// spu_host_ctrl: host-side controller for the SPU.
// Accepts host commands to preload instruction/data memory, launch a run and
// time it, and dump a data-memory window back over a response stream. While a
// run is in flight the memory ports are handed to the SPU (host_own=0).
module spu_host_ctrl #(
  parameter logic [15:0] TIMEOUT = 16'd4095
) (
  input  logic        clk,
  input  logic        rst,
  // host command stream
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  // host response stream
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic        resp_last,
  output logic        timeout_err,
  // SPU control
  output logic        host_own,
  output logic        spu_start,
  input  logic        spu_stop,
  // instruction-memory write port
  output logic        im_w_en,
  output logic [7:0]  im_w_addr,
  output logic [15:0] im_w_data,
  // data-memory port
  output logic        dm_w_en,
  output logic        dm_rd,
  output logic [7:0]  dm_addr,
  output logic [15:0] dm_w_data,
  input  logic [15:0] dm_r_data
);

  localparam logic [1:0] OP_LOAD_IM = 2'b00;
  localparam logic [1:0] OP_LOAD_DM = 2'b01;
  localparam logic [1:0] OP_RUN     = 2'b10;
  localparam logic [1:0] OP_DUMP    = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WRITE,
    S_RUN_START,
    S_RUN_ACK,
    S_RUN_WAIT,
    S_RESP,
    S_DUMP_RD,
    S_DUMP_CAP,
    S_DUMP_SEND
  } state_t;

  state_t      state;
  logic [15:0] cycle_cnt;   // run length counter
  logic [8:0]  remaining;   // dump words left; 9 bits so a length of 256 fits

  logic cmd_accept;
  logic resp_accept;

  assign cmd_accept  = cmd_valid & cmd_ready;
  assign resp_accept = resp_valid & resp_ready;

  // Controller FSM; every output is a flop loaded on the transition into the
  // state that owns it, so outputs are glitch-free and aligned with the state.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cycle_cnt   <= '0;
      remaining   <= '0;
      cmd_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_last   <= 1'b0;
      timeout_err <= 1'b0;
      host_own    <= 1'b0;
      spu_start   <= 1'b0;
      im_w_en     <= 1'b0;
      im_w_addr   <= '0;
      im_w_data   <= '0;
      dm_w_en     <= 1'b0;
      dm_rd       <= 1'b0;
      dm_addr     <= '0;
      dm_w_data   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          host_own  <= 1'b1;
          cmd_ready <= 1'b1;
          if (cmd_accept) begin
            cmd_ready <= 1'b0;
            case (cmd_op)
              OP_LOAD_IM: begin
                im_w_en   <= 1'b1;
                im_w_addr <= cmd_addr;
                im_w_data <= cmd_data;
                state     <= S_WRITE;
              end
              OP_LOAD_DM: begin
                dm_w_en   <= 1'b1;
                dm_addr   <= cmd_addr;
                dm_w_data <= cmd_data;
                state     <= S_WRITE;
              end
              OP_RUN: begin
                timeout_err <= 1'b0;
                cycle_cnt   <= '0;
                host_own    <= 1'b0;
                spu_start   <= 1'b1;
                state       <= S_RUN_START;
              end
              OP_DUMP: begin
                // dm_addr doubles as the dump pointer
                dm_addr   <= cmd_addr;
                dm_rd     <= 1'b1;
                remaining <= (cmd_data[7:0] == 8'd0) ? 9'd256 : {1'b0, cmd_data[7:0]};
                state     <= S_DUMP_RD;
              end
              default: state <= S_IDLE;
            endcase
          end
        end

        S_WRITE: begin
          im_w_en   <= 1'b0;
          dm_w_en   <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end

        S_RUN_START: begin
          spu_start <= 1'b0;
          state     <= S_RUN_ACK;
        end

        // Wait for a stop level left over from idle to fall before trusting it.
        S_RUN_ACK: begin
          if (cycle_cnt == TIMEOUT) begin
            timeout_err <= 1'b1;
            resp_data   <= 16'hFFFF;
            resp_valid  <= 1'b1;
            resp_last   <= 1'b1;
            host_own    <= 1'b1;
            state       <= S_RESP;
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
            if (!spu_stop) state <= S_RUN_WAIT;
          end
        end

        // A completed run wins over a timeout landing on the same cycle.
        S_RUN_WAIT: begin
          if (spu_stop) begin
            resp_data  <= cycle_cnt;
            resp_valid <= 1'b1;
            resp_last  <= 1'b1;
            host_own   <= 1'b1;
            state      <= S_RESP;
          end else if (cycle_cnt == TIMEOUT) begin
            timeout_err <= 1'b1;
            resp_data   <= 16'hFFFF;
            resp_valid  <= 1'b1;
            resp_last   <= 1'b1;
            host_own    <= 1'b1;
            state       <= S_RESP;
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end

        S_RESP: begin
          if (resp_accept) begin
            resp_valid <= 1'b0;
            resp_last  <= 1'b0;
            cmd_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end

        S_DUMP_RD: begin
          dm_rd <= 1'b0;
          state <= S_DUMP_CAP;
        end

        // Read data arrives one cycle after dm_rd.
        S_DUMP_CAP: begin
          resp_data  <= dm_r_data;
          resp_valid <= 1'b1;
          resp_last  <= (remaining == 9'd1);
          state      <= S_DUMP_SEND;
        end

        S_DUMP_SEND: begin
          if (resp_accept) begin
            resp_valid <= 1'b0;
            resp_last  <= 1'b0;
            remaining  <= remaining - 9'd1;
            dm_addr    <= dm_addr + 8'd1;
            if (remaining == 9'd1) begin
              cmd_ready <= 1'b1;
              state     <= S_IDLE;
            end else begin
              dm_rd <= 1'b1;
              state <= S_DUMP_RD;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spu_host_ctrl.sv
// Directed bench for spu_host_ctrl: loads, timed runs, timeout, dumps with
// back-pressure and wrap, and asynchronous reset in the middle of a dump.
module tb_spu_host_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        resp_last;
  logic        timeout_err;
  logic        host_own;
  logic        spu_start;
  logic        spu_stop;
  logic        im_w_en;
  logic [7:0]  im_w_addr;
  logic [15:0] im_w_data;
  logic        dm_w_en;
  logic        dm_rd;
  logic [7:0]  dm_addr;
  logic [15:0] dm_w_data;
  logic [15:0] dm_r_data;

  int vectors = 0;
  int miscompares = 0;

  // data memory seen by the DUT, and the bench's own expectation of it
  logic [15:0] dm_mem [256];
  logic [15:0] exp_mem [256];
  bit          mem_ready = 1'b0;

  spu_host_ctrl #(.TIMEOUT(16'd64)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_last(resp_last), .timeout_err(timeout_err),
    .host_own(host_own), .spu_start(spu_start), .spu_stop(spu_stop),
    .im_w_en(im_w_en), .im_w_addr(im_w_addr), .im_w_data(im_w_data),
    .dm_w_en(dm_w_en), .dm_rd(dm_rd), .dm_addr(dm_addr),
    .dm_w_data(dm_w_data), .dm_r_data(dm_r_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input int i);
    return 16'(32'hB000 + i);
  endfunction

  // synchronous data memory: one-cycle read latency
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) dm_mem[i] <= pat(i);
      mem_ready <= 1'b1;
    end else begin
      if (dm_w_en) dm_mem[dm_addr] <= dm_w_data;
      if (dm_rd) dm_r_data <= dm_mem[dm_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [15:0] data);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(input int bound);
    int n = 0;
    @(negedge clk);
    while (!resp_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) check("resp_wait_timeout", 32'(resp_valid), 32'd1);
  endtask

  task automatic take_resp;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check("resp_drop", 32'(resp_valid), 32'd0);
    check("idle_ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic load_dm(input logic [7:0] addr, input logic [15:0] data);
    send_cmd(2'b01, addr, data);
    exp_mem[addr] = data;
    @(negedge clk);
    check("ldm_en", 32'(dm_w_en), 32'd1);
    check("ldm_addr", 32'(dm_addr), 32'(addr));
    check("ldm_data", 32'(dm_w_data), 32'(data));
  endtask

  // stop falls at T+1 and rises at T+1+gap (T = start pulse); count = gap
  task automatic run_normal(input int gap);
    send_cmd(2'b10, 8'h00, 16'h0000);
    @(negedge clk);
    check("run_start", 32'(spu_start), 32'd1);
    check("run_own_T", 32'(host_own), 32'd0);
    check("run_terr_clr", 32'(timeout_err), 32'd0);
    check("run_busy", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1 spu_stop = 1'b0;
    @(negedge clk);
    check("run_start_1cyc", 32'(spu_start), 32'd0);
    for (int k = 0; k < gap - 1; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("run_own_mid", 32'(host_own), 32'd0);
      check("run_no_start", 32'(spu_start), 32'd0);
    end
    @(posedge clk);
    #1 spu_stop = 1'b1;
    @(negedge clk);
    check("run_own_stop", 32'(host_own), 32'd0);
    check("run_no_resp", 32'(resp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("run_resp_valid", 32'(resp_valid), 32'd1);
    check("run_count", 32'(resp_data), 32'(gap));
    check("run_last", 32'(resp_last), 32'd1);
    check("run_own_back", 32'(host_own), 32'd1);
    take_resp();
  endtask

  task automatic run_timeout;
    send_cmd(2'b10, 8'h00, 16'h0000);
    wait_resp(300);
    check("to_data", 32'(resp_data), 32'hFFFF);
    check("to_last", 32'(resp_last), 32'd1);
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_own", 32'(host_own), 32'd1);
    take_resp();
    check("to_err_sticky", 32'(timeout_err), 32'd1);
  endtask

  task automatic dump(input logic [7:0] base, input logic [7:0] len, input bit stall);
    int n;
    n = (len == 8'd0) ? 256 : int'(len);
    send_cmd(2'b11, base, {8'h00, len});
    for (int i = 0; i < n; i++) begin
      logic [7:0] a;
      a = base + 8'(i);
      wait_resp(20);
      check("dump_data", 32'(resp_data), 32'(exp_mem[a]));
      check("dump_last", 32'(resp_last), 32'(i == n - 1));
      if (stall) begin
        @(negedge clk);
        check("stall_valid", 32'(resp_valid), 32'd1);
        check("stall_data", 32'(resp_data), 32'(exp_mem[a]));
        check("stall_last", 32'(resp_last), 32'(i == n - 1));
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
    end
    @(negedge clk);
    check("dump_done_ready", 32'(cmd_ready), 32'd1);
    check("dump_done_valid", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    rst        = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_addr   = 8'h00;
    cmd_data   = 16'h0000;
    resp_ready = 1'b0;
    spu_stop   = 1'b1;
    for (int i = 0; i < 256; i++) exp_mem[i] = pat(i);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_own", 32'(host_own), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_start", 32'(spu_start), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("first_ready", 32'(cmd_ready), 32'd1);
    check("first_own", 32'(host_own), 32'd1);

    // instruction-memory load
    send_cmd(2'b00, 8'h05, 16'hA123);
    @(negedge clk);
    check("lim_en", 32'(im_w_en), 32'd1);
    check("lim_addr", 32'(im_w_addr), 32'h05);
    check("lim_data", 32'(im_w_data), 32'hA123);
    check("lim_busy", 32'(cmd_ready), 32'd0);
    check("lim_no_dm", 32'(dm_w_en), 32'd0);
    @(negedge clk);
    check("lim_en_off", 32'(im_w_en), 32'd0);
    check("lim_ready", 32'(cmd_ready), 32'd1);

    // data-memory loads
    load_dm(8'h10, 16'h5A5A);
    load_dm(8'hFE, 16'h1111);
    load_dm(8'hFF, 16'h2222);
    load_dm(8'h00, 16'h3333);

    // timed run, then timeout
    run_normal(10);
    run_timeout();

    // wrapped dump with back-pressure; timeout flag must survive it
    dump(8'hFE, 8'd3, 1'b1);
    check("terr_persist", 32'(timeout_err), 32'd1);

    // reset in the middle of a dump
    send_cmd(2'b11, 8'h10, 16'h0002);
    wait_resp(20);
    check("pre_rst_valid", 32'(resp_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(resp_valid), 32'd0);
    check("arst_own", 32'(host_own), 32'd0);
    check("arst_ready", 32'(cmd_ready), 32'd0);
    check("arst_terr", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_own", 32'(host_own), 32'd1);
    check("post_rst_valid", 32'(resp_valid), 32'd0);

    // a new run clears a standing timeout
    run_timeout();
    run_normal(3);

    // full 256-word dump
    dump(8'h00, 8'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
